// File: rtl/turf_trig_collect.sv
// Collects the phase-aligned soft/PPS/ext trigger sources once per sysclk window, checks their
// sequence numbers, applies a shared holdoff veto and serializes accepted triggers into a FWFT FIFO.
module turf_trig_collect #(
    parameter int CAPTURE_DELAY = 4,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rstn_i,
    input  logic        sysclk_phase_i,
    input  logic        running_i,
    input  logic [2:0]  src_mask_i,
    input  logic [15:0] trig_holdoff_i,
    input  logic [11:0] soft_addr_i,
    input  logic [11:0] pps_addr_i,
    input  logic [11:0] ext_addr_i,
    input  logic [7:0]  soft_meta_i,
    input  logic [7:0]  pps_meta_i,
    input  logic [7:0]  ext_meta_i,
    input  logic        soft_valid_i,
    input  logic        pps_valid_i,
    input  logic        ext_valid_i,
    output logic [11:0] trig_addr_o,
    output logic [1:0]  trig_src_o,
    output logic [6:0]  trig_seq_o,
    output logic        trig_valid_o,
    input  logic        trig_ready_i,
    output logic [15:0] drop_count_o,
    output logic [15:0] veto_count_o,
    output logic [15:0] seq_err_count_o,
    input  logic        count_clr_i
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NSRC = 3;
    localparam int EW   = 21;

    logic [11:0]             addr_in [NSRC];
    logic [7:0]              meta_in [NSRC];
    logic [NSRC-1:0]         valid_in;

    logic [CAPTURE_DELAY-1:0] phase_sr_reg;
    logic                    capture;
    logic                    veto;
    logic [NSRC-1:0]         hit, accept, seq_err, veto_hit, overwrite;
    logic [NSRC-1:0]         pending_reg;
    logic [6:0]              exp_seq_reg   [NSRC];
    logic [11:0]             slot_addr_reg [NSRC];
    logic [6:0]              slot_seq_reg  [NSRC];
    logic [15:0]             holdoff_reg;

    logic                    drain_valid;
    logic [1:0]              drain_sel;

    logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]             fifo_count_reg;
    logic                    fifo_full, push, pop;
    logic [EW-1:0]           fifo_head;

    logic [15:0]             drop_count_reg, veto_count_reg, seq_err_count_reg;
    logic [2:0]              drop_inc;

    assign addr_in[0] = soft_addr_i;
    assign addr_in[1] = pps_addr_i;
    assign addr_in[2] = ext_addr_i;
    assign meta_in[0] = soft_meta_i;
    assign meta_in[1] = pps_meta_i;
    assign meta_in[2] = ext_meta_i;
    assign valid_in   = {ext_valid_i, pps_valid_i, soft_valid_i};

    function automatic logic [2:0] ones3(input logic [2:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]};
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [2:0] inc);
        logic [16:0] s;
        s = {1'b0, c} + {14'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // A new phase pulse reloads the shifter so the capture point always tracks the latest pulse.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i)
            phase_sr_reg <= '0;
        else if (sysclk_phase_i)
            phase_sr_reg <= {{(CAPTURE_DELAY-1){1'b0}}, 1'b1};
        else
            phase_sr_reg <= phase_sr_reg << 1;
    end

    assign capture     = phase_sr_reg[CAPTURE_DELAY-1] && running_i;
    assign veto        = (holdoff_reg != 16'd0);
    assign drain_valid = running_i && (pending_reg != '0);

    always_comb begin
        drain_sel = 2'd0;
        if (pending_reg[2])
            drain_sel = 2'd2;
        else if (pending_reg[1])
            drain_sel = 2'd1;
    end

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign hit[gi]       = capture && valid_in[gi] && src_mask_i[gi];
            assign seq_err[gi]   = hit[gi] && (!meta_in[gi][7] || (meta_in[gi][6:0] != exp_seq_reg[gi]));
            assign accept[gi]    = hit[gi] && !veto;
            assign veto_hit[gi]  = hit[gi] && veto;
            // An entry being drained this very cycle is not lost, so it is not an overwrite.
            assign overwrite[gi] = accept[gi] && pending_reg[gi] && !(drain_valid && drain_sel == 2'(gi));
        end
    endgenerate

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            pending_reg <= '0;
            holdoff_reg <= '0;
            for (int s = 0; s < NSRC; s++) begin
                exp_seq_reg[s]   <= '0;
                slot_addr_reg[s] <= '0;
                slot_seq_reg[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (!running_i) begin
                    pending_reg[s] <= 1'b0;
                    exp_seq_reg[s] <= '0;
                end else begin
                    if (hit[s])
                        exp_seq_reg[s] <= meta_in[s][6:0] + 7'd1;
                    if (accept[s]) begin
                        pending_reg[s]   <= 1'b1;
                        slot_addr_reg[s] <= addr_in[s];
                        slot_seq_reg[s]  <= meta_in[s][6:0];
                    end else if (drain_valid && drain_sel == 2'(s)) begin
                        pending_reg[s] <= 1'b0;
                    end
                end
            end
            if (!running_i)
                holdoff_reg <= '0;
            else if ((accept != '0) && (trig_holdoff_i != 16'd0))
                holdoff_reg <= trig_holdoff_i;
            else if (holdoff_reg != 16'd0)
                holdoff_reg <= holdoff_reg - 16'd1;
        end
    end

    assign fifo_full = (fifo_count_reg == (AW+1)'(FIFO_DEPTH));
    assign push      = drain_valid && !fifo_full;
    assign pop       = (fifo_count_reg != '0) && trig_ready_i;
    assign fifo_head = fifo_mem[rd_ptr_reg];

    always_ff @(posedge sysclk_i) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {drain_sel, slot_seq_reg[drain_sel], slot_addr_reg[drain_sel]};
    end

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    assign drop_inc = ones3(overwrite) + {2'b00, drain_valid && fifo_full};

    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            drop_count_reg    <= '0;
            veto_count_reg    <= '0;
            seq_err_count_reg <= '0;
        end else if (count_clr_i) begin
            drop_count_reg    <= '0;
            veto_count_reg    <= '0;
            seq_err_count_reg <= '0;
        end else begin
            drop_count_reg    <= sat_add(drop_count_reg, drop_inc);
            veto_count_reg    <= sat_add(veto_count_reg, ones3(veto_hit));
            seq_err_count_reg <= sat_add(seq_err_count_reg, ones3(seq_err));
        end
    end

    assign trig_valid_o    = (fifo_count_reg != '0);
    assign trig_addr_o     = trig_valid_o ? fifo_head[11:0]  : 12'd0;
    assign trig_seq_o      = trig_valid_o ? fifo_head[18:12] : 7'd0;
    assign trig_src_o      = trig_valid_o ? fifo_head[20:19] : 2'd0;
    assign drop_count_o    = drop_count_reg;
    assign veto_count_o    = veto_count_reg;
    assign seq_err_count_o = seq_err_count_reg;

endmodule

// File: tb/tb_turf_trig_collect.sv
// Directed bench for turf_trig_collect: capture latency, drain order, holdoff, FIFO full,
// sequence checking, reset and run-state clearing.
module tb_turf_trig_collect;

    logic        sysclk_i = 1'b0;
    logic        sysclk_rstn_i = 1'b0;
    logic        sysclk_phase_i = 1'b0;
    logic        running_i = 1'b1;
    logic [2:0]  src_mask_i = 3'b111;
    logic [15:0] trig_holdoff_i = 16'd0;
    logic [11:0] soft_addr_i = '0, pps_addr_i = '0, ext_addr_i = '0;
    logic [7:0]  soft_meta_i = '0, pps_meta_i = '0, ext_meta_i = '0;
    logic        soft_valid_i = 1'b0, pps_valid_i = 1'b0, ext_valid_i = 1'b0;
    logic [11:0] trig_addr_o;
    logic [1:0]  trig_src_o;
    logic [6:0]  trig_seq_o;
    logic        trig_valid_o;
    logic        trig_ready_i = 1'b0;
    logic [15:0] drop_count_o, veto_count_o, seq_err_count_o;
    logic        count_clr_i = 1'b0;

    int checks = 0;
    int failures = 0;

    turf_trig_collect #(.CAPTURE_DELAY(4), .FIFO_DEPTH(16)) dut (
        .sysclk_i(sysclk_i), .sysclk_rstn_i(sysclk_rstn_i), .sysclk_phase_i(sysclk_phase_i),
        .running_i(running_i), .src_mask_i(src_mask_i), .trig_holdoff_i(trig_holdoff_i),
        .soft_addr_i(soft_addr_i), .pps_addr_i(pps_addr_i), .ext_addr_i(ext_addr_i),
        .soft_meta_i(soft_meta_i), .pps_meta_i(pps_meta_i), .ext_meta_i(ext_meta_i),
        .soft_valid_i(soft_valid_i), .pps_valid_i(pps_valid_i), .ext_valid_i(ext_valid_i),
        .trig_addr_o(trig_addr_o), .trig_src_o(trig_src_o), .trig_seq_o(trig_seq_o),
        .trig_valid_o(trig_valid_o), .trig_ready_i(trig_ready_i),
        .drop_count_o(drop_count_o), .veto_count_o(veto_count_o),
        .seq_err_count_o(seq_err_count_o), .count_clr_i(count_clr_i)
    );

    always #5 sysclk_i = ~sysclk_i;

    // One 8-clock window: phase pulse plus source data, called and returning on a falling edge.
    task automatic win(input logic [2:0] v, input logic [7:0] m0, input logic [7:0] m1,
                       input logic [7:0] m2, input logic [11:0] a0, input logic [11:0] a1,
                       input logic [11:0] a2);
        sysclk_phase_i = 1'b1;
        {ext_valid_i, pps_valid_i, soft_valid_i} = v;
        soft_meta_i = m0; pps_meta_i = m1; ext_meta_i = m2;
        soft_addr_i = a0; pps_addr_i = a1; ext_addr_i = a2;
        @(negedge sysclk_i);
        sysclk_phase_i = 1'b0;
        repeat (7) @(negedge sysclk_i);
        {ext_valid_i, pps_valid_i, soft_valid_i} = 3'b000;
    endtask

    task automatic clear_counters();
        count_clr_i = 1'b1;
        @(negedge sysclk_i);
        count_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sysclk_i);
        checks++;
        if (trig_valid_o !== 1'b0 || trig_addr_o !== 12'd0 || trig_src_o !== 2'd0 || trig_seq_o !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%0b addr=%h src=%0d seq=%0d, expected all 0",
                     trig_valid_o, trig_addr_o, trig_src_o, trig_seq_o);
        end
        checks++;
        if (drop_count_o !== 16'd0 || veto_count_o !== 16'd0 || seq_err_count_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got drop=%0d veto=%0d seqerr=%0d, expected 0 0 0",
                     drop_count_o, veto_count_o, seq_err_count_o);
        end
        sysclk_rstn_i = 1'b1;
        @(negedge sysclk_i);
        $display("test_reset done");
    endtask

    task automatic test_soft_seq();
        trig_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            win(3'b001, 8'h80 + 8'(i), 8'h00, 8'h00, 12'h123, 12'h000, 12'h000);
        checks++;
        if (seq_err_count_o !== 16'd0) begin
            failures++;
            $display("FAIL soft_seqerr: got %0d expected 0", seq_err_count_o);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (trig_valid_o !== 1'b1 || trig_src_o !== 2'd0 || trig_seq_o !== 7'(i) || trig_addr_o !== 12'h123) begin
                failures++;
                $display("FAIL soft_entry%0d: got valid=%0b src=%0d seq=%0d addr=%h, expected 1 0 %0d 123",
                         i, trig_valid_o, trig_src_o, trig_seq_o, trig_addr_o, i);
            end
            trig_ready_i = 1'b1;
            @(negedge sysclk_i);
            trig_ready_i = 1'b0;
        end
        checks++;
        if (trig_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL soft_empty: got valid=%0b expected 0", trig_valid_o);
        end
        $display("test_soft_seq done");
    endtask

    task automatic test_all_three();
        logic [1:0]  exp_src [3];
        logic [6:0]  exp_seq [3];
        logic [11:0] exp_addr [3];
        exp_src  = '{2'd2, 2'd1, 2'd0};
        exp_seq  = '{7'd0, 7'd0, 7'd3};
        exp_addr = '{12'hC02, 12'hB01, 12'hA00};
        trig_ready_i = 1'b1;
        sysclk_phase_i = 1'b1;
        {ext_valid_i, pps_valid_i, soft_valid_i} = 3'b111;
        soft_meta_i = 8'h83; pps_meta_i = 8'h80; ext_meta_i = 8'h80;
        soft_addr_i = 12'hA00; pps_addr_i = 12'hB01; ext_addr_i = 12'hC02;
        for (int k = 1; k <= 5; k++) begin
            @(negedge sysclk_i);
            sysclk_phase_i = 1'b0;
            checks++;
            if (trig_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL lat_early_c%0d: got valid=%0b expected 0", k, trig_valid_o);
            end
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge sysclk_i);
            checks++;
            if (trig_valid_o !== 1'b1 || trig_src_o !== exp_src[j] || trig_seq_o !== exp_seq[j] || trig_addr_o !== exp_addr[j]) begin
                failures++;
                $display("FAIL order%0d: got valid=%0b src=%0d seq=%0d addr=%h, expected 1 %0d %0d %h",
                         j, trig_valid_o, trig_src_o, trig_seq_o, trig_addr_o, exp_src[j], exp_seq[j], exp_addr[j]);
            end
        end
        {ext_valid_i, pps_valid_i, soft_valid_i} = 3'b000;
        @(negedge sysclk_i);
        checks++;
        if (trig_valid_o !== 1'b0 || seq_err_count_o !== 16'd0) begin
            failures++;
            $display("FAIL order_end: got valid=%0b seqerr=%0d expected 0 0", trig_valid_o, seq_err_count_o);
        end
        trig_ready_i = 1'b0;
        $display("test_all_three done");
    endtask

    task automatic test_holdoff();
        int exp_veto;
        clear_counters();
        trig_holdoff_i = 16'd20;
        trig_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            win(3'b010, 8'h00, 8'h81 + 8'(i), 8'h00, 12'h000, 12'h055, 12'h000);
            exp_veto = (i == 0) ? 0 : ((i == 3) ? 2 : i);
            checks++;
            if (veto_count_o !== 16'(exp_veto)) begin
                failures++;
                $display("FAIL holdoff_veto_w%0d: got %0d expected %0d", i + 1, veto_count_o, exp_veto);
            end
        end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (trig_valid_o !== 1'b1 || trig_src_o !== 2'd1 || trig_seq_o !== ((j == 0) ? 7'd1 : 7'd4)) begin
                failures++;
                $display("FAIL holdoff_entry%0d: got valid=%0b src=%0d seq=%0d, expected 1 1 %0d",
                         j, trig_valid_o, trig_src_o, trig_seq_o, (j == 0) ? 1 : 4);
            end
            trig_ready_i = 1'b1;
            @(negedge sysclk_i);
            trig_ready_i = 1'b0;
        end
        checks++;
        if (trig_valid_o !== 1'b0 || seq_err_count_o !== 16'd0) begin
            failures++;
            $display("FAIL holdoff_end: got valid=%0b seqerr=%0d expected 0 0", trig_valid_o, seq_err_count_o);
        end
        trig_holdoff_i = 16'd0;
        repeat (24) @(negedge sysclk_i);
        $display("test_holdoff done");
    endtask

    task automatic test_fifo_full();
        clear_counters();
        trig_ready_i = 1'b0;
        for (int i = 0; i < 17; i++)
            win(3'b001, 8'h84 + 8'(i), 8'h00, 8'h00, 12'h3C0 + 12'(i), 12'h000, 12'h000);
        checks++;
        if (drop_count_o !== 16'd1 || seq_err_count_o !== 16'd0) begin
            failures++;
            $display("FAIL full_counts: got drop=%0d seqerr=%0d expected 1 0", drop_count_o, seq_err_count_o);
        end
        trig_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (trig_valid_o !== 1'b1 || trig_seq_o !== 7'(4 + i) || trig_addr_o !== 12'h3C0 + 12'(i)) begin
                failures++;
                $display("FAIL full_pop%0d: got valid=%0b seq=%0d addr=%h, expected 1 %0d %h",
                         i, trig_valid_o, trig_seq_o, trig_addr_o, 4 + i, 12'h3C0 + 12'(i));
            end
            @(negedge sysclk_i);
        end
        checks++;
        if (trig_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL full_empty: got valid=%0b expected 0", trig_valid_o);
        end
        trig_ready_i = 1'b0;
        $display("test_fifo_full done");
    endtask

    task automatic test_seq_check();
        logic [7:0] metas [4];
        int exp_err [4];
        metas   = '{8'h80, 8'h82, 8'h83, 8'h04};
        exp_err = '{0, 1, 1, 2};
        running_i = 1'b0;
        @(negedge sysclk_i);
        running_i = 1'b1;
        clear_counters();
        trig_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            win(3'b100, 8'h00, 8'h00, metas[i], 12'h000, 12'h000, 12'h7E0);
            checks++;
            if (seq_err_count_o !== 16'(exp_err[i])) begin
                failures++;
                $display("FAIL seq_w%0d meta=%h: got seqerr=%0d expected %0d",
                         i, metas[i], seq_err_count_o, exp_err[i]);
            end
        end
        src_mask_i = 3'b110;
        win(3'b001, 8'h00, 8'h00, 8'h00, 12'h111, 12'h000, 12'h000);
        checks++;
        if (seq_err_count_o !== 16'd2 || trig_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL masked_soft: got seqerr=%0d valid=%0b expected 2 0", seq_err_count_o, trig_valid_o);
        end
        src_mask_i = 3'b111;
        trig_ready_i = 1'b0;
        $display("test_seq_check done");
    endtask

    task automatic test_reset_running();
        clear_counters();
        trig_ready_i = 1'b0;
        sysclk_phase_i = 1'b1;
        {ext_valid_i, pps_valid_i, soft_valid_i} = 3'b111;
        soft_meta_i = 8'h00; pps_meta_i = 8'h00; ext_meta_i = 8'h00;
        @(negedge sysclk_i);
        sysclk_phase_i = 1'b0;
        repeat (5) @(negedge sysclk_i);
        checks++;
        if (trig_valid_o !== 1'b1 || seq_err_count_o !== 16'd3) begin
            failures++;
            $display("FAIL middrain_pre: got valid=%0b seqerr=%0d expected 1 3", trig_valid_o, seq_err_count_o);
        end
        sysclk_rstn_i = 1'b0;
        #1;
        checks++;
        if (trig_valid_o !== 1'b0 || seq_err_count_o !== 16'd0 || drop_count_o !== 16'd0 || veto_count_o !== 16'd0) begin
            failures++;
            $display("FAIL middrain_reset: got valid=%0b seqerr=%0d drop=%0d veto=%0d expected all 0",
                     trig_valid_o, seq_err_count_o, drop_count_o, veto_count_o);
        end
        {ext_valid_i, pps_valid_i, soft_valid_i} = 3'b000;
        @(negedge sysclk_i);
        sysclk_rstn_i = 1'b1;
        @(negedge sysclk_i);
        checks++;
        if (trig_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_empty: got valid=%0b expected 0", trig_valid_o);
        end
        trig_holdoff_i = 16'd20;
        win(3'b010, 8'h00, 8'h80, 8'h00, 12'h000, 12'h0AA, 12'h000);
        running_i = 1'b0;
        repeat (2) @(negedge sysclk_i);
        running_i = 1'b1;
        win(3'b010, 8'h00, 8'h80, 8'h00, 12'h000, 12'h0BB, 12'h000);
        checks++;
        if (veto_count_o !== 16'd0 || seq_err_count_o !== 16'd0) begin
            failures++;
            $display("FAIL run_drop_counts: got veto=%0d seqerr=%0d expected 0 0", veto_count_o, seq_err_count_o);
        end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (trig_valid_o !== 1'b1 || trig_src_o !== 2'd1 || trig_seq_o !== 7'd0 ||
                trig_addr_o !== ((j == 0) ? 12'h0AA : 12'h0BB)) begin
                failures++;
                $display("FAIL run_drop_entry%0d: got valid=%0b src=%0d seq=%0d addr=%h, expected 1 1 0 %h",
                         j, trig_valid_o, trig_src_o, trig_seq_o, trig_addr_o, (j == 0) ? 12'h0AA : 12'h0BB);
            end
            trig_ready_i = 1'b1;
            @(negedge sysclk_i);
            trig_ready_i = 1'b0;
        end
        checks++;
        if (trig_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL run_drop_empty: got valid=%0b expected 0", trig_valid_o);
        end
        $display("test_reset_running done");
    endtask

    initial begin
        test_reset();
        test_soft_seq();
        test_all_three();
        test_holdoff();
        test_fifo_full();
        test_seq_check();
        test_reset_running();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
